// File: rtl/present_sbox_serial_ctrl.sv
// Serial sequencer for a shared, pipelined 3-share masked PRESENT S-box: feeds 16 nibbles, collects 16 results.
// Optional build macro PRESENT_SBOX_ZEROIZE_EN scrubs S-box inputs and shift registers when idle.
module present_sbox_serial_ctrl #(
    parameter int NIBBLES  = 16,
    parameter int SBOX_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   state_in1,
    input  logic [4*NIBBLES-1:0]   state_in2,
    input  logic [4*NIBBLES-1:0]   state_in3,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   state_out1,
    output logic [4*NIBBLES-1:0]   state_out2,
    output logic [4*NIBBLES-1:0]   state_out3,
    output logic [3:0]             sbox_in1,
    output logic [3:0]             sbox_in2,
    output logic [3:0]             sbox_in3,
    output logic                   sbox_in_valid,
    input  logic [3:0]             sbox_out1,
    input  logic [3:0]             sbox_out2,
    input  logic [3:0]             sbox_out3
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES) + 1;
    localparam logic [CW-1:0] LAST_FEED = CW'(NIBBLES - 1);
    localparam logic [CW-1:0] ALL_NIB   = CW'(NIBBLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0][W-1:0]      in_sr_q, in_sr_d;
    logic [2:0][W-1:0]      out_sr_q, out_sr_d;
    logic [2:0][W-1:0]      state_out_q, state_out_d;
    logic [CW-1:0]          feed_cnt_q, feed_cnt_d;
    logic [CW-1:0]          col_cnt_q, col_cnt_d;
    logic [SBOX_LAT-1:0]    vpipe_q, vpipe_d;

    logic [2:0][W-1:0]      state_in_w;
    logic [2:0][3:0]        sbox_out_w;
    logic [2:0][3:0]        sbox_in_w;
    logic                   feed_w;
    logic                   capture_w;

    assign state_in_w = {state_in3, state_in2, state_in1};
    assign sbox_out_w = {sbox_out3, sbox_out2, sbox_out1};

    assign feed_w        = (state_q == ST_FEED);
    assign sbox_in_valid = feed_w;
    assign busy          = (state_q == ST_FEED) || (state_q == ST_DRAIN);
    assign done          = (state_q == ST_DONE);
    assign capture_w     = vpipe_q[SBOX_LAT-1] && busy;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_share
`ifdef PRESENT_SBOX_ZEROIZE_EN
            assign sbox_in_w[gi] = feed_w ? in_sr_q[gi][3:0] : 4'h0;
`else
            assign sbox_in_w[gi] = in_sr_q[gi][3:0];
`endif
        end
    endgenerate

    assign sbox_in1   = sbox_in_w[0];
    assign sbox_in2   = sbox_in_w[1];
    assign sbox_in3   = sbox_in_w[2];
    assign state_out1 = state_out_q[0];
    assign state_out2 = state_out_q[1];
    assign state_out3 = state_out_q[2];

    always_comb begin
        state_d     = state_q;
        in_sr_d     = in_sr_q;
        out_sr_d    = out_sr_q;
        state_out_d = state_out_q;
        feed_cnt_d  = feed_cnt_q;
        col_cnt_d   = col_cnt_q;
        vpipe_d     = SBOX_LAT'({vpipe_q, feed_w});

        // Result nibbles enter at the top so nibble 0 lands at [3:0] after the last capture.
        if (capture_w) begin
            for (int s = 0; s < 3; s++) begin
                out_sr_d[s] = {sbox_out_w[s], out_sr_q[s][W-1:4]};
            end
            if (col_cnt_q != ALL_NIB) begin
                col_cnt_d = col_cnt_q + CW'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    in_sr_d    = state_in_w;
                    feed_cnt_d = '0;
                    col_cnt_d  = '0;
                    state_d    = ST_FEED;
                end
            end
            ST_FEED: begin
                // Rotate so the input registers hold only the original share data afterwards.
                for (int s = 0; s < 3; s++) begin
                    in_sr_d[s] = {in_sr_q[s][3:0], in_sr_q[s][W-1:4]};
                end
                if (feed_cnt_q != ALL_NIB) begin
                    feed_cnt_d = feed_cnt_q + CW'(1);
                end
                if (feed_cnt_q == LAST_FEED) begin
                    state_d = ST_DRAIN;
`ifdef PRESENT_SBOX_ZEROIZE_EN
                    in_sr_d = '0;
`endif
                end
            end
            ST_DRAIN: begin
                // Look at the post-capture count so done follows the final capture directly.
                if (col_cnt_d == ALL_NIB) begin
                    state_d     = ST_DONE;
                    state_out_d = out_sr_d;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
`ifdef PRESENT_SBOX_ZEROIZE_EN
                out_sr_d = '0;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_sr_q     <= '0;
            out_sr_q    <= '0;
            state_out_q <= '0;
            feed_cnt_q  <= '0;
            col_cnt_q   <= '0;
            vpipe_q     <= '0;
        end else begin
            state_q     <= state_d;
            in_sr_q     <= in_sr_d;
            out_sr_q    <= out_sr_d;
            state_out_q <= state_out_d;
            feed_cnt_q  <= feed_cnt_d;
            col_cnt_q   <= col_cnt_d;
            vpipe_q     <= vpipe_d;
        end
    end

endmodule

// File: tb/tb_present_sbox_serial_ctrl.sv
// Directed bench for present_sbox_serial_ctrl with a 2-stage share-wise S-box model
// whose output shares XOR to the PRESENT S-box of the combined input nibble.
module tb_present_sbox_serial_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] state_in1, state_in2, state_in3;
    logic        busy, done, sbox_in_valid;
    logic [63:0] state_out1, state_out2, state_out3;
    logic [3:0]  sbox_in1, sbox_in2, sbox_in3;
    logic [3:0]  sbox_out1, sbox_out2, sbox_out3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    present_sbox_serial_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .state_in1     (state_in1),
        .state_in2     (state_in2),
        .state_in3     (state_in3),
        .busy          (busy),
        .done          (done),
        .state_out1    (state_out1),
        .state_out2    (state_out2),
        .state_out3    (state_out3),
        .sbox_in1      (sbox_in1),
        .sbox_in2      (sbox_in2),
        .sbox_in3      (sbox_in3),
        .sbox_in_valid (sbox_in_valid),
        .sbox_out1     (sbox_out1),
        .sbox_out2     (sbox_out2),
        .sbox_out3     (sbox_out3)
    );

    function automatic logic [3:0] present_s(input logic [3:0] x);
        case (x)
            4'h0: present_s = 4'hC;  4'h1: present_s = 4'h5;
            4'h2: present_s = 4'h6;  4'h3: present_s = 4'hB;
            4'h4: present_s = 4'h9;  4'h5: present_s = 4'h0;
            4'h6: present_s = 4'hA;  4'h7: present_s = 4'hD;
            4'h8: present_s = 4'h3;  4'h9: present_s = 4'hE;
            4'hA: present_s = 4'hF;  4'hB: present_s = 4'h8;
            4'hC: present_s = 4'h4;  4'hD: present_s = 4'h7;
            4'hE: present_s = 4'h1;  default: present_s = 4'h2;
        endcase
    endfunction

    // Two-stage S-box model; shares 2 and 3 pass through as masks, share 1 carries S(x)^masks.
    logic [11:0] stage1, stage2;
    always @(posedge clk) begin
        stage1 <= {present_s(sbox_in1 ^ sbox_in2 ^ sbox_in3) ^ sbox_in2 ^ sbox_in3, sbox_in2, sbox_in3};
        stage2 <= stage1;
    end
    assign sbox_out1 = stage2[11:8];
    assign sbox_out2 = stage2[7:4];
    assign sbox_out3 = stage2[3:0];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int zero_err = 0;

    // Run one operation from an IDLE cycle; returns timing observations.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                          output int done_cyc, output int busy_cyc, output int valid_cyc,
                          output int order_err, output int valid_span);
        int cyc;
        int first_v;
        int last_v;
        state_in1 = a; state_in2 = b; state_in3 = c;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; done_cyc = 0; busy_cyc = 0; valid_cyc = 0; order_err = 0;
        first_v = 0; last_v = 0;
        while (done_cyc == 0 && cyc < 40) begin
            if (busy) busy_cyc++;
            if (sbox_in_valid) begin
                if (valid_cyc < 16) begin
                    if (sbox_in1 !== a[4*valid_cyc +: 4] || sbox_in2 !== b[4*valid_cyc +: 4] ||
                        sbox_in3 !== c[4*valid_cyc +: 4])
                        order_err++;
                end
                if (valid_cyc == 0) first_v = cyc;
                last_v = cyc;
                valid_cyc++;
            end else begin
`ifdef PRESENT_SBOX_ZEROIZE_EN
                if (sbox_in1 !== 4'h0 || sbox_in2 !== 4'h0 || sbox_in3 !== 4'h0) zero_err++;
`endif
            end
            if (done) begin
                done_cyc = cyc;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        valid_span = last_v - first_v + 1;
        $display("op in1=%h in2=%h in3=%h done_cyc=%0d xor=%h", a, b, c, done_cyc,
                 state_out1 ^ state_out2 ^ state_out3);
    endtask

    localparam logic [63:0] V1   = 64'h0123456789ABCDEF;
    localparam logic [63:0] R1   = 64'hC56B90AD3EF84712;
    localparam logic [63:0] V2   = 64'hFEDCBA9876543210;
    localparam logic [63:0] R2   = 64'h21748FE3DA09B65C;
    localparam logic [63:0] M2   = 64'h5A5A1234DEADBEEF;
    localparam logic [63:0] M3   = 64'h0F0F9876CAFEBABE;

    initial begin
        int dc, bc, vc, oe, vs, ndone;
        rst = 1'b1; start = 1'b0;
        state_in1 = '0; state_in2 = '0; state_in3 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_valid", {63'd0, sbox_in_valid}, 64'd0);
        check_eq("rst_sbox_in", {52'd0, sbox_in1, sbox_in2, sbox_in3}, 64'd0);
        check_eq("rst_out", state_out1 | state_out2 | state_out3, 64'd0);

        // Test 1
        run_op(V1, 64'd0, 64'd0, dc, bc, vc, oe, vs);
        check_eq("t1_done_cyc", 64'(dc), 64'd19);
        check_eq("t1_xor", state_out1 ^ state_out2 ^ state_out3, R1);
        check_eq("t1_out1", state_out1, R1);
        @(posedge clk); #1;
        check_eq("t1_hold", state_out1, R1);
        check_eq("t1_idle_busy", {63'd0, busy}, 64'd0);

        // Test 2
        run_op(64'd0, 64'd0, 64'd0, dc, bc, vc, oe, vs);
        check_eq("t2_xor", state_out1 ^ state_out2 ^ state_out3, 64'hCCCCCCCCCCCCCCCC);
        check_eq("t2_busy_cycles", 64'(bc), 64'd18);
        @(posedge clk); #1;

        // Test 3
        run_op(V1 ^ M2 ^ M3, M2, M3, dc, bc, vc, oe, vs);
        check_eq("t3_xor", state_out1 ^ state_out2 ^ state_out3, R1);
        check_eq("t3_share2", state_out2, M2);
        check_eq("t3_share3", state_out3, M3);
        check_eq("t3_valid_cycles", 64'(vc), 64'd16);
        check_eq("t3_valid_span", 64'(vs), 64'd16);
        check_eq("t3_nibble_order", 64'(oe), 64'd0);
        @(posedge clk); #1;

        // Test 4: start pulses during FEED and DONE are ignored
        state_in1 = V1; state_in2 = '0; state_in3 = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        state_in1 = V2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40 && ndone == 0; i++) begin
            if (done) ndone++;
            else begin @(posedge clk); #1; end
        end
        check_eq("t4_done_seen", 64'(ndone), 64'd1);
        check_eq("t4_result", state_out1 ^ state_out2 ^ state_out3, R1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("t4_done_start_ignored", {63'd0, busy}, 64'd0);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check_eq("t4_no_extra_op", 64'(ndone), 64'd0);
        check_eq("t4_out_held", state_out1, R1);
        run_op(V2, 64'd0, 64'd0, dc, bc, vc, oe, vs);
        check_eq("t4_next_op", state_out1 ^ state_out2 ^ state_out3, R2);
        @(posedge clk); #1;

        // Test 5: reset during the 8th feed cycle
        state_in1 = V1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check_eq("t5_in_feed", {63'd0, sbox_in_valid}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("t5_busy", {63'd0, busy}, 64'd0);
        check_eq("t5_valid", {63'd0, sbox_in_valid}, 64'd0);
        check_eq("t5_out_cleared", state_out1 | state_out2 | state_out3, 64'd0);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) ndone++;
            @(posedge clk); #1;
        end
        check_eq("t5_no_done", 64'(ndone), 64'd0);
        run_op(V1, 64'd0, 64'd0, dc, bc, vc, oe, vs);
        check_eq("t5_recover", state_out1 ^ state_out2 ^ state_out3, R1);

        // Test 6: back-to-back, start on the cycle after done
        @(posedge clk); #1;
        run_op(V2 ^ M3, M2 ^ M3, M2, dc, bc, vc, oe, vs);
        check_eq("t6_b2b_done_cyc", 64'(dc), 64'd19);
        check_eq("t6_b2b_xor", state_out1 ^ state_out2 ^ state_out3, R2);
        check_eq("t6_zeroize", 64'(zero_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
